mmio_bus_fabric: RTL and testbench

//  Parametrised memory-mapped interconnect between the MIPS data port and NUM_SLAVES targets
//  (slave 0 = DMEM, slaves 1..N-1 = peripherals such as factorial and GPIO).

---
 rtl/mmio_bus_fabric.sv | 155 +++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_fabric.sv
// Memory-mapped interconnect between the MIPS data port and NUM_SLAVES targets.
// One transaction at a time; unmapped regions and slave timeouts complete with a bus error.
module mmio_bus_fabric #(
  parameter int          NUM_SLAVES   = 4,
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          SEL_LSB      = 8,
  parameter int          SEL_W        = 4,
  parameter int          FIRST_PERIPH = 8,
  parameter int          TIMEOUT      = 15,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wd,
  output logic                         m_busy,
  output logic                         m_done,
  output logic                         m_err,
  output logic [DATA_W-1:0]            m_rd,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wd,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int SLOT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = {{(NUM_SLAVES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state, next_state;
  logic [SLOT_W-1:0] slot, map_slot;
  logic              map_hit;
  logic [SEL_W-1:0]  region;
  logic [TMR_W-1:0]  timer;
  logic              err_flag;
  logic              ready_hit, time_up;
  logic [DATA_W-1:0] sel_rd;
  logic              sel_ready;

  // Region 0 always belongs to slave 0; peripherals occupy consecutive regions from FIRST_PERIPH.
  always_comb begin
    region   = m_addr[SEL_LSB +: SEL_W];
    map_hit  = 1'b0;
    map_slot = '0;
    if (region == '0) map_hit = 1'b1;
    for (int i = 1; i < NUM_SLAVES; i++) begin
      if (int'(region) == FIRST_PERIPH + i - 1) begin
        map_hit  = 1'b1;
        map_slot = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    sel_rd    = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot == SLOT_W'(i)) begin
        sel_rd    = s_rd[i*DATA_W +: DATA_W];
        sel_ready = s_ready[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // A ready arriving in the last allowed wait cycle beats the timeout.
  always_comb begin
    next_state = state;
    ready_hit  = 1'b0;
    time_up    = 1'b0;
    case (state)
      ST_IDLE: if (m_req) next_state = map_hit ? ST_WAIT : ST_RESP;
      ST_WAIT: begin
        ready_hit = sel_ready;
        time_up   = (timer == TMR_W'(TIMEOUT - 1));
        if (ready_hit || time_up) next_state = ST_RESP;
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign m_busy = (state != ST_IDLE);
  assign m_done = (state == ST_RESP);
  assign m_err  = m_done & err_flag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wd      <= '0;
      slot      <= '0;
      timer     <= '0;
      err_flag  <= 1'b0;
      m_rd      <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_req) begin
            s_addr <= m_addr;
            if (map_hit) begin
              s_sel    <= SEL_ONE << map_slot;
              s_we     <= m_we;
              s_wd     <= m_wd;
              slot     <= map_slot;
              timer    <= '0;
              err_flag <= 1'b0;
            end else begin
              s_sel    <= '0;
              err_flag <= 1'b1;
              m_rd     <= DATA_W'(ERR_DATA);
              err_addr <= m_addr;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        ST_WAIT: begin
          if (ready_hit) begin
            if (!s_we) m_rd <= sel_rd;
            s_sel    <= '0;
            s_we     <= 1'b0;
            err_flag <= 1'b0;
          end else if (time_up) begin
            s_sel    <= '0;
            s_we     <= 1'b0;
            err_flag <= 1'b1;
            m_rd     <= DATA_W'(ERR_DATA);
            err_addr <= s_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Scoreboard bench for mmio_bus_fabric: stimulus pushes expected responses, a monitor checks each m_done.
module tb_mmio_bus_fabric;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           m_req = 1'b0;
  logic           m_we = 1'b0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_wd = '0;
  logic           m_busy, m_done, m_err;
  logic [DW-1:0]  m_rd;
  logic [NS-1:0]  s_sel;
  logic           s_we;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wd;
  logic [NS*DW-1:0] s_rd;
  logic [NS-1:0]  s_ready = '0;
  logic [7:0]     err_count;
  logic [AW-1:0]  err_addr;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    logic [7:0]  cnt;
    logic [31:0] eaddr;
  } resp_t;

  resp_t       expq[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] expRd = '0;
  logic [7:0]  expCnt = '0;
  logic [31:0] expEaddr = '0;

  mmio_bus_fabric dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
    .m_busy(m_busy), .m_done(m_done), .m_err(m_err), .m_rd(m_rd),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
    .s_rd(s_rd), .s_ready(s_ready),
    .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clock = ~clock;

  assign s_rd = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1234};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Any completion with nothing queued is a spurious transaction.
  always @(negedge clock) begin
    resp_t e;
    if (reset && m_done) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got m_done=1 expected no completion");
      end else begin
        e = expq.pop_front();
        checkOutput("m_err", {31'b0, m_err}, {31'b0, e.err});
        checkOutput("m_rd", m_rd, e.rd);
        checkOutput("err_count", {24'b0, err_count}, {24'b0, e.cnt});
        checkOutput("err_addr", err_addr, e.eaddr);
        checkOutput("s_sel_at_done", {28'b0, s_sel}, 32'h0);
      end
    end
  end

  task automatic pushExpect(input logic we, input logic [31:0] addr, input logic err, input logic [31:0] slaveData);
    resp_t e;
    if (err) begin
      expRd = ERRV;
      if (expCnt != 8'hFF) expCnt = expCnt + 8'd1;
      expEaddr = addr;
    end else if (!we) begin
      expRd = slaveData;
    end
    e.err = err; e.rd = expRd; e.cnt = expCnt; e.eaddr = expEaddr;
    expq.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clock); #1;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wd = wd;
    @(posedge clock); #1;
    m_req = 1'b0;
  endtask

  // readyAt > 0 raises s_ready[slaveIdx] just after the edge ending wait cycle readyAt.
  task automatic waitDone(input int readyAt, input int slaveIdx, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      cycles++;
      if (m_done) ok = 1'b1;
      else if (cycles == readyAt) begin
        @(posedge clock); #1;
        s_ready[slaveIdx] = 1'b1;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: got no m_done within 40 cycles expected completion");
    end
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic err, input logic [31:0] slaveData, input logic [NS-1:0] preReady,
                               input int readyAt, input int slaveIdx, input int expCycles);
    int cycles;
    bit ok;
    pushExpect(we, addr, err, slaveData);
    s_ready = preReady;
    issue(we, addr, wd);
    waitDone(readyAt, slaveIdx, cycles, ok);
    if (ok) checkOutput({name, "_latency"}, cycles, expCycles);
    s_ready = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    bit ok;

    #1;
    checkOutput("reset_busy_done_err", {29'b0, m_busy, m_done, m_err}, 32'h0);
    checkOutput("reset_m_rd", m_rd, 32'h0);
    checkOutput("reset_s_sel_we", {27'b0, s_we, s_sel}, 32'h0);
    checkOutput("reset_s_addr_wd", s_addr | s_wd, 32'h0);
    checkOutput("reset_err_count", {24'b0, err_count}, 32'h0);
    checkOutput("reset_err_addr", err_addr, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    applyStimulus("read_r0", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_1234, 4'b0001, 0, 0, 2);

    // Write to region 9 lands on slave 2; strobes last one wait cycle.
    pushExpect(1'b1, 32'h0000_0904, 1'b0, 32'h0);
    s_ready = 4'b0100;
    issue(1'b1, 32'h0000_0904, 32'h5);
    @(negedge clock);
    checkOutput("wr_s_sel", {28'b0, s_sel}, 32'h4);
    checkOutput("wr_s_we", {31'b0, s_we}, 32'h1);
    checkOutput("wr_s_wd", s_wd, 32'h5);
    checkOutput("wr_s_addr", s_addr, 32'h904);
    @(negedge clock);
    checkOutput("wr_done", {31'b0, m_done}, 32'h1);
    checkOutput("wr_s_we_after", {31'b0, s_we}, 32'h0);
    s_ready = '0;

    applyStimulus("unmapped_b", 1'b0, 32'h0000_0B00, 32'h0, 1'b1, 32'h0, 4'b1111, 0, 0, 1);
    applyStimulus("read_r10", 1'b0, 32'h0000_0A00, 32'h0, 1'b0, 32'h3333_0003, 4'b1000, 0, 0, 2);
    applyStimulus("unmapped_7", 1'b0, 32'h0000_0700, 32'h0, 1'b1, 32'h0, 4'b0000, 0, 0, 1);
    applyStimulus("timeout_s1", 1'b0, 32'h0000_0800, 32'h0, 1'b1, 32'h0, 4'b1101, 0, 0, 16);
    applyStimulus("ready_c15", 1'b0, 32'h0000_08F0, 32'h0, 1'b0, 32'h1111_0001, 4'b0000, 14, 1, 16);
    checkOutput("read_after_ready_c15", m_rd, 32'h1111_0001);

    for (int i = 0; i < 256; i++)
      applyStimulus("sat", 1'b0, 32'h0000_0F00 | 32'(i), 32'h0, 1'b1, 32'h0, 4'b0000, 0, 0, 1);
    checkOutput("err_count_sat", {24'b0, err_count}, 32'hFF);

    // A request pulsed while busy must be dropped, not queued.
    pushExpect(1'b0, 32'h0000_0004, 1'b0, 32'h0000_1234);
    s_ready = '0;
    issue(1'b0, 32'h0000_0004, 32'h0);
    @(posedge clock); #1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0900; m_wd = 32'h7;
    @(posedge clock); #1;
    m_req = 1'b0;
    @(negedge clock);
    checkOutput("busy_s_addr", s_addr, 32'h4);
    checkOutput("busy_s_sel_we", {27'b0, s_we, s_sel}, 32'h1);
    @(posedge clock); #1;
    s_ready = 4'b0001;
    waitDone(0, 0, cycles, ok);
    s_ready = '0;
    repeat (6) @(negedge clock);
    checkOutput("busy_idle_after", {31'b0, m_busy}, 32'h0);

    // Asynchronous reset mid-wait drops the transaction without a completion.
    issue(1'b0, 32'h0000_0900, 32'h0);
    @(negedge clock);
    checkOutput("rst_pre_s_sel", {28'b0, s_sel}, 32'h4);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_async_s_sel", {28'b0, s_sel}, 32'h0);
    checkOutput("rst_async_busy", {31'b0, m_busy}, 32'h0);
    expRd = '0; expCnt = '0; expEaddr = '0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("rst_err_count", {24'b0, err_count}, 32'h0);
    applyStimulus("after_reset", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_1234, 4'b0001, 0, 0, 2);

    repeat (4) @(negedge clock);
    checkOutput("queue_empty", expq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
